// File: rtl/dffrnq_rn_sequencer_if.sv
// Request/status bundle between control logic and dffrnq_rn_sequencer.
// Optional DFFRNQ_RN_SEQ_STATUS_EN adds stage_cnt and abort_seen.
interface dffrnq_rn_sequencer_if #(
   parameter int NUM_STAGES = 4
);
   logic                  req;
   logic                  pwr_ok;
   logic [NUM_STAGES-1:0] rn;
   logic                  busy;
   logic                  ack;

`ifdef DFFRNQ_RN_SEQ_STATUS_EN
   localparam int STAGE_W = $clog2(NUM_STAGES + 1);

   logic [STAGE_W-1:0]    stage_cnt;
   logic                  abort_seen;

   modport master (
      output req, pwr_ok,
      input  rn, busy, ack,
      input  stage_cnt, abort_seen
   );

   modport slave (
      input  req, pwr_ok,
      output rn, busy, ack,
      output stage_cnt, abort_seen
   );
`else
   modport master (
      output req, pwr_ok,
      input  rn, busy, ack
   );

   modport slave (
      input  req, pwr_ok,
      output rn, busy, ack
   );
`endif
endinterface

// File: rtl/dffrnq_rn_sequencer.sv
// Staged release of active-low RN pins for banks of dffrnq flops.
// Optional DFFRNQ_RN_SEQ_STATUS_EN adds stage_cnt / abort_seen status.
module dffrnq_rn_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   dffrnq_rn_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ASSERT,
      S_RELEASE,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_SAT =
      CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LAST =
      CNT_W'(GAP_CYCLES - 1);
   localparam logic [NUM_STAGES-1:0] RN_LSB =
      NUM_STAGES'(1);

   state_t                state_q;
   state_t                state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [NUM_STAGES-1:0] rn_q;
   logic [NUM_STAGES-1:0] rn_d;
   logic                  busy_q;
   logic                  busy_d;
   logic                  ack_q;
   logic                  ack_d;

   // Next state, counter and registered-output values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rn_d    = rn_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               state_d = S_ASSERT;
               cnt_d   = '0;
               rn_d    = '0;
               busy_d  = 1'b1;
            end
         end
         S_ASSERT: begin
            if (cnt_q >= HOLD_LAST) begin
               if (bus.pwr_ok) begin
                  state_d = S_RELEASE;
                  cnt_d   = '0;
                  rn_d    = RN_LSB;
               end else begin
                  cnt_d = HOLD_SAT;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RELEASE: begin
            if (!bus.pwr_ok || bus.req) begin
               state_d = S_ASSERT;
               cnt_d   = '0;
               rn_d    = '0;
            end else if (&rn_q) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               ack_d   = 1'b1;
            end else if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               rn_d  = (rn_q << 1) | RN_LSB;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.req) begin
               state_d = S_ASSERT;
               cnt_d   = '0;
               rn_d    = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_ASSERT;
            cnt_d   = '0;
            rn_d    = '0;
            busy_d  = 1'b1;
         end
      endcase
   end

   // State and output flops; reset holds every bank low
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ASSERT;
         cnt_q   <= '0;
         rn_q    <= '0;
         busy_q  <= 1'b1;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rn_q    <= rn_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.rn   = rn_q;
   assign bus.busy = busy_q;
   assign bus.ack  = ack_q;

`ifdef DFFRNQ_RN_SEQ_STATUS_EN
   localparam int STAGE_W = $clog2(NUM_STAGES + 1);

   logic [STAGE_W-1:0] stage_q;
   logic               abort_q;
   logic               abort;

   function automatic logic [STAGE_W-1:0] ones(
      input logic [NUM_STAGES-1:0] v
   );
      ones = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         ones = ones + STAGE_W'(v[i]);
      end
   endfunction

   assign abort = (state_q == S_RELEASE) && !bus.pwr_ok;

   // Released-bank count tracks rn; abort flag is sticky until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= '0;
         abort_q <= 1'b0;
      end else begin
         stage_q <= ones(rn_d);
         abort_q <= abort_q | abort;
      end
   end

   assign bus.stage_cnt  = stage_q;
   assign bus.abort_seen = abort_q;
`endif

endmodule

// File: tb/tb_dffrnq_rn_sequencer.sv
// Scoreboard bench for dffrnq_rn_sequencer (NUM=4, HOLD=16, GAP=4).
// Status outputs are checked when DFFRNQ_RN_SEQ_STATUS_EN is defined.
module tb_dffrnq_rn_sequencer;
   localparam int N  = 4;
   localparam int SW = $clog2(N + 1);
   localparam int VW = N + 3 + SW;

`ifdef DFFRNQ_RN_SEQ_STATUS_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   typedef struct {
      string         name;
      int            cyc;
      logic [N-1:0]  rn;
      logic          busy;
      logic          ack;
      logic          ab;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   ev_t  q[$];

   dffrnq_rn_sequencer_if #(.NUM_STAGES(N)) bus ();

   dffrnq_rn_sequencer #(
      .NUM_STAGES (N),
      .HOLD_CYCLES(16),
      .GAP_CYCLES (4),
      .CNT_W      (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

`ifdef DFFRNQ_RN_SEQ_STATUS_EN
   wire [SW-1:0] sc_obs = bus.stage_cnt;
   wire          ab_obs = bus.abort_seen;
`else
   wire [SW-1:0] sc_obs = '0;
   wire          ab_obs = 1'b0;
`endif

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: cyc=%0d still running", cyc);
      $fatal(1, "timeout");
   end

   task automatic push(input string n, input int c,
                       input logic [N-1:0] r, input logic b,
                       input logic a, input logic ab);
      ev_t e;
      e.name = n;
      e.cyc  = c;
      e.rn   = r;
      e.busy = b;
      e.ack  = a;
      e.ab   = ab;
      q.push_back(e);
   endtask

   task automatic push_rel(input string n, input int r,
                           input logic ab);
      push({n, "_rn0"}, r,      4'b0001, 1'b1, 1'b0, ab);
      push({n, "_rn1"}, r + 4,  4'b0011, 1'b1, 1'b0, ab);
      push({n, "_rn2"}, r + 8,  4'b0111, 1'b1, 1'b0, ab);
      push({n, "_rn3"}, r + 12, 4'b1111, 1'b1, 1'b0, ab);
      push({n, "_ack"}, r + 13, 4'b1111, 1'b0, 1'b1, ab);
   endtask

   task automatic push_idle(input string n, input int c,
                            input logic ab);
      push(n, c, 4'b1111, 1'b0, 1'b0, ab);
   endtask

   task automatic goto(input int e);
      while (cyc < e - 1) @(negedge clk);
   endtask

   task automatic req_pulse(input int t);
      goto(t);
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
   endtask

   // Monitor: every output change pops and checks one event
   initial begin
      logic [VW-1:0] prev;
      logic [VW-1:0] now;
      logic [VW-1:0] want;
      ev_t           e;
      prev = 'x;
      forever begin
         @(negedge clk);
         now = {bus.rn, bus.busy, bus.ack, ab_obs, sc_obs};
         if (now !== prev) begin
            prev = now;
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change: cyc=%0d got=%b want no change",
                        cyc, now);
            end else begin
               e = q.pop_front();
               want = {e.rn, e.busy, e.ack,
                       STAT ? e.ab : 1'b0,
                       STAT ? SW'($countones(e.rn)) : SW'(0)};
               if (now !== want ||
                   (e.cyc >= 0 && e.cyc != cyc)) begin
                  failures++;
                  $display("FAIL %s: cyc=%0d got=%b want cyc=%0d val=%b",
                           e.name, cyc, now, e.cyc, want);
               end
            end
         end
      end
   end

   // Directed stimulus; expectations queued ahead of each scenario
   initial begin
      int t;
      rst        = 1'b1;
      bus.req    = 1'b0;
      bus.pwr_ok = 1'b1;

      push("reset", -1, 4'b0000, 1'b1, 1'b0, 1'b0);
      push_rel("pwron", 19, 1'b0);
      push_idle("pwron_idle", 33, 1'b0);
      goto(4);
      rst = 1'b0;
      goto(36);

      t = cyc + 2;
      push("req_assert", t, 4'b0000, 1'b1, 1'b0, 1'b0);
      push_rel("req", t + 16, 1'b0);
      push_idle("req_idle", t + 30, 1'b0);
      req_pulse(t);
      goto(t + 32);

      t = cyc + 2;
      push("pg_assert", t, 4'b0000, 1'b1, 1'b0, 1'b0);
      push_rel("pg", t + 22, 1'b0);
      push_idle("pg_idle", t + 36, 1'b0);
      goto(t);
      bus.pwr_ok = 1'b0;
      req_pulse(t);
      goto(t + 22);
      bus.pwr_ok = 1'b1;
      goto(t + 38);

      t = cyc + 2;
      push("rr_assert", t, 4'b0000, 1'b1, 1'b0, 1'b0);
      push("rr_rn0", t + 16, 4'b0001, 1'b1, 1'b0, 1'b0);
      push("rr_restart", t + 18, 4'b0000, 1'b1, 1'b0, 1'b0);
      push_rel("rr", t + 34, 1'b0);
      push_idle("rr_idle", t + 48, 1'b0);
      req_pulse(t);
      req_pulse(t + 18);
      goto(t + 50);

      t = cyc + 2;
      push("ab_assert", t, 4'b0000, 1'b1, 1'b0, 1'b0);
      push("ab_rn0", t + 16, 4'b0001, 1'b1, 1'b0, 1'b0);
      push("ab_rn1", t + 20, 4'b0011, 1'b1, 1'b0, 1'b0);
      push("ab_rn2", t + 24, 4'b0111, 1'b1, 1'b0, 1'b0);
      push("abort", t + 25, 4'b0000, 1'b1, 1'b0, 1'b1);
      push_rel("ab", t + 41, 1'b1);
      push_idle("ab_idle", t + 55, 1'b1);
      req_pulse(t);
      goto(t + 25);
      bus.pwr_ok = 1'b0;
      @(negedge clk);
      bus.pwr_ok = 1'b1;
      goto(t + 57);

      t = cyc + 2;
      push("hold_assert", t, 4'b0000, 1'b1, 1'b0, 1'b1);
      push("hold_rn0", t + 16, 4'b0001, 1'b1, 1'b0, 1'b1);
      push("rst_mid", t + 18, 4'b0000, 1'b1, 1'b0, 1'b0);
      push_rel("post_rst", t + 34, 1'b0);
      push_idle("post_rst_idle", t + 48, 1'b0);
      req_pulse(t);
      goto(t + 5);
      bus.req = 1'b1;
      goto(t + 11);
      bus.req = 1'b0;
      goto(t + 18);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      goto(t + 50);

      bus.pwr_ok = 1'b0;
      repeat (3) @(negedge clk);
      bus.pwr_ok = 1'b1;

      t = cyc + 2;
      push("dn_assert", t, 4'b0000, 1'b1, 1'b0, 1'b0);
      push_rel("dn", t + 16, 1'b0);
      push("done_restart", t + 30, 4'b0000, 1'b1, 1'b0, 1'b0);
      push_rel("dn2", t + 46, 1'b0);
      push_idle("dn2_idle", t + 60, 1'b0);
      req_pulse(t);
      req_pulse(t + 30);
      goto(t + 62);

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL pending_events: left=%0d want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
